// File: rtl/dmac_pkg.sv
// Shared types and constants for the single-channel DMA controller.
// Holds the FSM state encoding, register-select codes and MODE bit positions.
package dmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_XFER   = 3'd2,
    S_MREAD  = 3'd3,
    S_MWRITE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'b00;
  localparam logic [1:0] REG_CNT  = 2'b01;
  localparam logic [1:0] REG_DST  = 2'b10;
  localparam logic [1:0] REG_MODE = 2'b11;

  localparam int MODE_DIR    = 0;
  localparam int MODE_SINGLE = 1;
  localparam int MODE_M2M    = 2;
  localparam int MODE_DEC    = 3;

  // Addresses wrap naturally modulo 2^16 in both directions.
  function automatic logic [15:0] step_addr(input logic [15:0] a, input logic dec);
    return dec ? (a - 16'd1) : (a + 16'd1);
  endfunction

endpackage

// File: rtl/dmac_regfile.sv
// Programmable registers of the DMA channel: SRC, CNT, DST and MODE,
// with write decode and the address step / count decrement datapath.
module dmac_regfile
  import dmac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  sel,
  input  logic [15:0] wdata,
  input  logic        step_src,
  input  logic        step_dst,
  input  logic        dec_cnt,
  output logic [15:0] src,
  output logic [15:0] cnt,
  output logic [15:0] dst,
  output logic [3:0]  mode,
  output logic [15:0] src_nxt
);

  // Reserved MODE bits have no readback path, so only the decoded bits are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src  <= 16'h0000;
      cnt  <= 16'h0000;
      dst  <= 16'h0000;
      mode <= 4'h0;
    end else begin
      if (we) begin
        unique case (sel)
          REG_SRC:  src  <= wdata;
          REG_CNT:  cnt  <= wdata;
          REG_DST:  dst  <= wdata;
          REG_MODE: mode <= wdata[3:0];
          default:  ;
        endcase
      end
      if (step_src) src <= step_addr(src, mode[MODE_DEC]);
      if (step_dst) dst <= step_addr(dst, mode[MODE_DEC]);
      if (dec_cnt && (cnt != 16'h0000)) cnt <= cnt - 16'd1;
    end
  end

  // Value SRC will hold after this edge; lets the FSM register the next address.
  assign src_nxt = step_src ? step_addr(src, mode[MODE_DEC]) : src;

endmodule

// File: rtl/dmac.sv
// Single-channel DMA controller: bus hold/grant handshake, fly-by and
// memory-to-memory transfers, Moore outputs registered from the next state.
module dmac
  import dmac_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        DREQ,
  input  logic        HLDA,
  input  logic        BG,
  input  logic        RDY,
  input  logic        REGW,
  input  logic [1:0]  REGSEL,
  input  logic [15:0] Setup,
  input  logic [7:0]  Data_in,
  output logic        HLD,
  output logic        DACK,
  output logic        MEMR,
  output logic        MEMW,
  output logic        IOR,
  output logic        IOW,
  output logic        EOP,
  output logic [15:0] Addrbus,
  output logic [7:0]  Data_out,
  output state_t      state_dbg
);

  state_t      state, nxt;
  logic        grant, step_src, step_dst, dec_cnt, latch, dir;
  logic [15:0] src, cnt, dst, src_nxt;
  logic [3:0]  mode;
  logic [7:0]  buffer;

  assign grant     = HLDA | BG;
  assign dir       = mode[MODE_DIR];
  assign state_dbg = state;

  dmac_regfile u_regfile (
    .clk      (CLK),
    .rst_n    (RST),
    .we       (REGW && (state == S_IDLE)),
    .sel      (REGSEL),
    .wdata    (Setup),
    .step_src (step_src),
    .step_dst (step_dst),
    .dec_cnt  (dec_cnt),
    .src      (src),
    .cnt      (cnt),
    .dst      (dst),
    .mode     (mode),
    .src_nxt  (src_nxt)
  );

  // Losing DREQ releases the bus entirely; losing only the grant re-arbitrates.
  always_comb begin
    nxt      = state;
    step_src = 1'b0;
    step_dst = 1'b0;
    dec_cnt  = 1'b0;
    latch    = 1'b0;
    unique case (state)
      S_IDLE: if (DREQ) nxt = (cnt != 16'h0000) ? S_REQ : S_DONE;
      S_REQ: begin
        if (!DREQ)      nxt = S_IDLE;
        else if (grant) nxt = mode[MODE_M2M] ? S_MREAD : S_XFER;
      end
      S_XFER, S_MREAD, S_MWRITE: begin
        if (!DREQ)       nxt = S_IDLE;
        else if (!grant) nxt = S_REQ;
        else if (RDY) begin
          if (state == S_MREAD) begin
            latch = 1'b1;
            nxt   = S_MWRITE;
          end else begin
            step_src = 1'b1;
            step_dst = (state == S_MWRITE);
            dec_cnt  = 1'b1;
            if (cnt == 16'd1)          nxt = S_DONE;
            else if (mode[MODE_SINGLE]) nxt = S_IDLE;
            else                        nxt = (state == S_MWRITE) ? S_MREAD : S_XFER;
          end
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      buffer   <= 8'h00;
      HLD      <= 1'b0;
      DACK     <= 1'b0;
      MEMR     <= 1'b0;
      MEMW     <= 1'b0;
      IOR      <= 1'b0;
      IOW      <= 1'b0;
      EOP      <= 1'b0;
      Addrbus  <= 16'h0000;
      Data_out <= 8'h00;
    end else begin
      state <= nxt;
      if (latch) buffer <= Data_in;
      HLD  <= (nxt == S_REQ) || (nxt == S_XFER) || (nxt == S_MREAD) || (nxt == S_MWRITE);
      DACK <= (nxt == S_XFER);
      MEMR <= ((nxt == S_XFER) && !dir) || (nxt == S_MREAD);
      MEMW <= ((nxt == S_XFER) && dir) || (nxt == S_MWRITE);
      IOR  <= (nxt == S_XFER) && dir;
      IOW  <= (nxt == S_XFER) && !dir;
      EOP  <= (nxt == S_DONE);
      if ((nxt == S_XFER) || (nxt == S_MREAD)) Addrbus <= src_nxt;
      else if (nxt == S_MWRITE)                Addrbus <= dst;
      else                                     Addrbus <= 16'h0000;
      Data_out <= (nxt == S_MWRITE) ? (latch ? Data_in : buffer) : 8'h00;
    end
  end

endmodule

// File: tb/tb_dmac.sv
// Bench for dmac: spec-level transfer model checked every cycle, directed
// scenarios with literal address logs, then randomized bus traffic.
module tb_dmac;
  import dmac_pkg::*;

  logic        CLK = 1'b0, RST = 1'b0;
  logic        DREQ = 1'b0, HLDA = 1'b0, BG = 1'b0, RDY = 1'b0, REGW = 1'b0;
  logic [1:0]  REGSEL = 2'b00;
  logic [15:0] Setup = 16'h0000;
  logic [7:0]  Data_in = 8'h00;
  logic        HLD, DACK, MEMR, MEMW, IOR, IOW, EOP;
  logic [15:0] Addrbus;
  logic [7:0]  Data_out;
  state_t      state_dbg;

  dmac dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .HLDA(HLDA), .BG(BG), .RDY(RDY),
    .REGW(REGW), .REGSEL(REGSEL), .Setup(Setup), .Data_in(Data_in),
    .HLD(HLD), .DACK(DACK), .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW),
    .EOP(EOP), .Addrbus(Addrbus), .Data_out(Data_out), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // behavioural model: phases of a transfer, registers as plain numbers
  localparam int P_IDLE = 0, P_WAIT = 1, P_MOVE = 2, P_RD = 3, P_WR = 4, P_FIN = 5;
  int          ph;
  logic [15:0] m_src, m_cnt, m_dst, m_mode;
  logic [7:0]  m_buf;

  task automatic model_step();
    logic        g;
    logic [15:0] delta;
    int          nph;
    g   = HLDA | BG;
    nph = ph;
    case (ph)
      P_IDLE: begin
        if (DREQ) nph = (m_cnt != 0) ? P_WAIT : P_FIN;
        if (REGW) begin
          case (REGSEL)
            2'd0: m_src = Setup;
            2'd1: m_cnt = Setup;
            2'd2: m_dst = Setup;
            default: m_mode = Setup;
          endcase
        end
      end
      P_WAIT: begin
        if (!DREQ) nph = P_IDLE;
        else if (g) nph = m_mode[2] ? P_RD : P_MOVE;
      end
      P_MOVE, P_RD, P_WR: begin
        if (!DREQ) nph = P_IDLE;
        else if (!g) nph = P_WAIT;
        else if (RDY) begin
          if (ph == P_RD) begin
            m_buf = Data_in;
            nph   = P_WR;
          end else begin
            delta = m_mode[3] ? 16'hFFFF : 16'h0001;
            m_src = m_src + delta;
            if (ph == P_WR) m_dst = m_dst + delta;
            if (m_cnt == 1) nph = P_FIN;
            else if (m_mode[1]) nph = P_IDLE;
            else nph = (ph == P_WR) ? P_RD : P_MOVE;
            m_cnt = m_cnt - 16'd1;
          end
        end
      end
      default: nph = P_IDLE;
    endcase
    ph = nph;
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ph = P_IDLE; m_src = 0; m_cnt = 0; m_dst = 0; m_mode = 0; m_buf = 0;
    end else begin
      model_step();
    end
  end

  function automatic logic [30:0] exp_vec();
    logic mv, d;
    logic [15:0] a;
    mv = (ph == P_MOVE);
    d  = m_mode[0];
    a  = (mv || ph == P_RD) ? m_src : ((ph == P_WR) ? m_dst : 16'h0000);
    return {(ph == P_WAIT) || mv || (ph == P_RD) || (ph == P_WR), mv,
            (mv && !d) || (ph == P_RD), (mv && d) || (ph == P_WR),
            mv && d, mv && !d, ph == P_FIN, a,
            (ph == P_WR) ? m_buf : 8'h00};
  endfunction

  function automatic logic [30:0] dut_vec();
    return {HLD, DACK, MEMR, MEMW, IOR, IOW, EOP, Addrbus, Data_out};
  endfunction

  // scoreboard: per-cycle compare plus a strobe log for directed tests
  logic [27:0] exp_q[$];
  logic [27:0] log_q[$];
  int   eop_cnt = 0, hld_rises = 0;
  logic hld_q = 1'b0;
  bit   log_en = 0, chk_en = 0;

  always @(posedge CLK) begin
    #2;
    if (RST && chk_en) begin
      chk("cycle", {1'b0, dut_vec()}, {1'b0, exp_vec()});
      if (log_en) begin
        if (MEMR | MEMW | IOR | IOW) log_q.push_back({MEMR, MEMW, IOR, IOW, Addrbus, Data_out});
        if (EOP) eop_cnt++;
        if (HLD && !hld_q) hld_rises++;
      end
    end
    hld_q = HLD;
  end

  // driver tasks
  task automatic wr(input logic [1:0] sel, input logic [15:0] d);
    @(negedge CLK);
    REGW = 1'b1; REGSEL = sel; Setup = d;
    @(negedge CLK);
    REGW = 1'b0;
  endtask

  task automatic start_test();
    log_q.delete(); exp_q.delete();
    eop_cnt = 0; hld_rises = 0; log_en = 1;
  endtask

  task automatic ex(input logic [3:0] s, input logic [15:0] a, input logic [7:0] d, input int n);
    repeat (n) exp_q.push_back({s, a, d});
  endtask

  task automatic run_xfer(input bit ws, input bit wr_mid);
    int hold = 0;
    bit done = 0, ws_en = ws, wr_en = wr_mid;
    @(negedge CLK);
    DREQ = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      REGW = 1'b0;
      if (EOP) begin
        DREQ = 1'b0; done = 1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) RDY = 1'b1;
      end else if (ws_en && DACK && Addrbus == 16'h00CD) begin
        RDY = 1'b0; hold = 2; ws_en = 0;
      end
      if (wr_en && DACK && Addrbus == 16'h0301) begin
        REGW = 1'b1; REGSEL = REG_SRC; Setup = 16'h9999; wr_en = 0;
      end
    end
    if (!done) chk("eop_timeout", 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  task automatic check_log(input string name);
    int n;
    chk({name, "_len"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(name, {4'h0, log_q[i]}, {4'h0, exp_q[i]});
    log_en = 0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {1'b0, dut_vec()}, 32'd0);
    RST = 1'b1; chk_en = 1; HLDA = 1'b1; RDY = 1'b1;

    // burst fly-by I/O->memory
    wr(REG_SRC, 16'h00CC); wr(REG_CNT, 16'd3); wr(REG_MODE, 16'h0001);
    start_test();
    ex(4'b0110, 16'h00CC, 8'h00, 1); ex(4'b0110, 16'h00CD, 8'h00, 1); ex(4'b0110, 16'h00CE, 8'h00, 1);
    run_xfer(0, 0);
    check_log("burst"); chk("burst_eop", eop_cnt, 1);

    // wait states on the second transfer
    wr(REG_SRC, 16'h00CC); wr(REG_CNT, 16'd3);
    start_test();
    ex(4'b0110, 16'h00CC, 8'h00, 1); ex(4'b0110, 16'h00CD, 8'h00, 3); ex(4'b0110, 16'h00CE, 8'h00, 1);
    run_xfer(1, 0);
    check_log("wait"); chk("wait_eop", eop_cnt, 1);

    // single mode memory->I/O
    wr(REG_SRC, 16'h0040); wr(REG_CNT, 16'd2); wr(REG_MODE, 16'h0002);
    start_test();
    ex(4'b1001, 16'h0040, 8'h00, 1); ex(4'b1001, 16'h0041, 8'h00, 1);
    run_xfer(0, 0);
    check_log("single"); chk("single_eop", eop_cnt, 1); chk("single_rereq", hld_rises, 2);

    // memory-to-memory
    wr(REG_SRC, 16'h0100); wr(REG_DST, 16'h0200); wr(REG_CNT, 16'd2); wr(REG_MODE, 16'h0004);
    Data_in = 8'h5A;
    start_test();
    ex(4'b1000, 16'h0100, 8'h00, 1); ex(4'b0100, 16'h0200, 8'h5A, 1);
    ex(4'b1000, 16'h0101, 8'h00, 1); ex(4'b0100, 16'h0201, 8'h5A, 1);
    run_xfer(0, 0);
    check_log("m2m"); chk("m2m_eop", eop_cnt, 1);

    // address wrap upward
    wr(REG_SRC, 16'hFFFF); wr(REG_CNT, 16'd2); wr(REG_MODE, 16'h0001);
    start_test();
    ex(4'b0110, 16'hFFFF, 8'h00, 1); ex(4'b0110, 16'h0000, 8'h00, 1);
    run_xfer(0, 0);
    check_log("wrap_up");

    // address wrap downward in decrement mode
    wr(REG_SRC, 16'h0001); wr(REG_CNT, 16'd3); wr(REG_MODE, 16'h0009);
    start_test();
    ex(4'b0110, 16'h0001, 8'h00, 1); ex(4'b0110, 16'h0000, 8'h00, 1); ex(4'b0110, 16'hFFFF, 8'h00, 1);
    run_xfer(0, 0);
    check_log("wrap_down");

    // zero count: EOP with no strobes and no bus request
    wr(REG_CNT, 16'd0);
    start_test();
    run_xfer(0, 0);
    check_log("cnt0"); chk("cnt0_eop", eop_cnt, 1); chk("cnt0_hld", hld_rises, 0);

    // register write during XFER is ignored; SRC continues from 0x0304
    wr(REG_SRC, 16'h0300); wr(REG_CNT, 16'd4); wr(REG_MODE, 16'h0001);
    start_test();
    for (int i = 0; i < 4; i++) ex(4'b0110, 16'h0300 + 16'(i), 8'h00, 1);
    run_xfer(0, 1);
    check_log("regw_xfer");
    wr(REG_CNT, 16'd1);
    start_test();
    ex(4'b0110, 16'h0304, 8'h00, 1);
    run_xfer(0, 0);
    check_log("regw_kept");

    // reset mid-burst
    wr(REG_SRC, 16'h0500); wr(REG_CNT, 16'd5);
    @(negedge CLK); DREQ = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge CLK);
        if (DACK && Addrbus == 16'h0502) seen = 1;
      end
      chk("mid_burst_reached", {31'd0, seen}, 32'd1);
    end
    #2 RST = 1'b0;
    #1 chk("rst_mid_outputs", {1'b0, dut_vec()}, 32'd0);
    DREQ = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      HLDA    = ($urandom_range(0, 9) < 6);
      BG      = ($urandom_range(0, 9) < 2);
      DREQ    = ($urandom_range(0, 9) < 8);
      RDY     = ($urandom_range(0, 9) < 7);
      REGW    = ($urandom_range(0, 9) < 2);
      REGSEL  = 2'($urandom_range(0, 3));
      Setup   = (REGSEL == REG_CNT) ? 16'($urandom_range(0, 5)) : 16'($urandom);
      Data_in = 8'($urandom);
    end
    @(negedge CLK);
    DREQ = 1'b0; REGW = 1'b0;
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
